// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte-in / serial-out handshake plus baud tick and baud-counter enable
interface uart_tx_serializer_if #(parameter int DW = 8);
    logic          baud_tick;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;
    logic          baud_en;
    modport master (
        output baud_tick, tx_start, tx_data,
        input  tx, tx_busy, tx_done, baud_en
    );
    modport slave (
        input  baud_tick, tx_start, tx_data,
        output tx, tx_busy, tx_done, baud_en
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shifts a latched word out as start, LSB-first data, optional parity, 1-2 stop bits
module uart_tx_serializer #(
    parameter int DW         = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_serializer_if.slave bus
);
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        r_state;
    logic [DW-1:0] r_shift;
    logic [CW-1:0] r_cnt;
    logic          r_stop;
    logic          r_par;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_stop  <= 1'b0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.tx_start) begin
                    r_shift <= bus.tx_data;
                    r_par   <= ^bus.tx_data ^ PARITY_ODD[0];
                    r_state <= START;
                    r_tx    <= 1'b0;
                    r_busy  <= 1'b1;
                end
                START: if (bus.baud_tick) begin
                    r_state <= DATA;
                    r_tx    <= r_shift[0];
                    r_cnt   <= '0;
                end
                DATA: if (bus.baud_tick) begin
                    if (r_cnt != LAST_BIT) begin
                        r_shift <= r_shift >> 1;
                        r_tx    <= r_shift[1];
                        r_cnt   <= r_cnt + 1'b1;
                    end else if (PARITY_EN != 0) begin
                        r_state <= PARITY;
                        r_tx    <= r_par;
                    end else begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                        r_stop  <= 1'b0;
                    end
                end
                PARITY: if (bus.baud_tick) begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                    r_stop  <= 1'b0;
                end
                STOP: if (bus.baud_tick) begin
                    if (r_stop == LAST_STOP) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_stop <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.tx      = r_tx;
    assign bus.tx_busy = r_busy;
    assign bus.tx_done = r_done;
    assign bus.baud_en = r_busy;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: four parameter variants driven by directed and random frames against a bit-list model
module tb_uart_tx_serializer;
    localparam int PE[4]  = '{0, 1, 1, 0};
    localparam int ODD[4] = '{0, 0, 1, 0};
    localparam int SB[4]  = '{1, 1, 1, 2};
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] st, tk;
    logic [7:0] dat [4];
    logic [3:0] txo, bsy, dn, ben;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : gi
        uart_tx_serializer_if #(.DW(8)) b ();
        assign b.tx_start  = st[g];
        assign b.baud_tick = tk[g];
        assign b.tx_data   = dat[g];
        assign txo[g] = b.tx;
        assign bsy[g] = b.tx_busy;
        assign dn[g]  = b.tx_done;
        assign ben[g] = b.baud_en;
        uart_tx_serializer #(
            .DW(8), .PARITY_EN(PE[g]), .PARITY_ODD(ODD[g]), .STOP_BITS(SB[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(b)
        );
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int k, input logic act, input logic exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s inst%0d got %b want %b", tag, k, act, exp);
        end
    endtask
    task automatic chk_int(input string tag, input int k, input int act, input int exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s inst%0d got %0d want %0d", tag, k, act, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_tx"}, k, txo[k], 1'b1);
            chk({tag, "_busy"}, k, bsy[k], 1'b0);
            chk({tag, "_done"}, k, dn[k], 1'b0);
            chk({tag, "_en"}, k, ben[k], 1'b0);
        end
    endtask
    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            st = '0;
            tk = 4'($urandom);
            step();
            chk_idle("idle");
        end
        tk = '0;
    endtask
    // per = 0 picks a random 1..4 clk bit period per bit; abort_bit < 0 means run to completion
    task automatic send(input int k, input logic [7:0] d, input int per, input bit inj,
                        input int abort_bit, input bit b2b);
        bit q[$];
        int ones, p, busy_cnt;
        ones = $countones(d);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (PE[k] != 0) q.push_back(((ones % 2) == 1) ^ (ODD[k] != 0));
        for (int i = 0; i < SB[k]; i++) q.push_back(1'b1);
        st[k] = 1'b1;
        dat[k] = d;
        tk[k] = 1'($urandom);
        step();
        st[k] = 1'b0;
        tk[k] = 1'b0;
        dat[k] = 8'($urandom);
        chk("accept_busy", k, bsy[k], 1'b1);
        chk("accept_en", k, ben[k], 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < q.size(); i++) begin
            p = (per > 0) ? per : int'($urandom_range(1, 4));
            for (int c = 0; c < p; c++) begin
                if (i == abort_bit && c == 0) begin
                    chk("pre_abort_tx", k, txo[k], q[i]);
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    chk_idle("abort");
                    for (int j = 0; j < 3; j++) begin
                        step();
                        chk_idle("post_abort");
                    end
                    return;
                end
                chk($sformatf("bit%0d", i), k, txo[k], q[i]);
                chk("mid_busy", k, bsy[k], 1'b1);
                chk("mid_done", k, dn[k], 1'b0);
                busy_cnt += int'(bsy[k]);
                tk[k] = (c == p - 1);
                if (inj && i == 3 && c == 0) begin
                    st[k] = 1'b1;
                    dat[k] = 8'h3C;
                end
                step();
                st[k] = 1'b0;
                tk[k] = 1'b0;
            end
        end
        chk("end_done", k, dn[k], 1'b1);
        chk("end_busy", k, bsy[k], 1'b0);
        chk("end_en", k, ben[k], 1'b0);
        chk("end_tx", k, txo[k], 1'b1);
        if (per > 0) chk_int("busy_len", k, busy_cnt, per * q.size());
        if (!b2b) begin
            step();
            chk("done_pulse", k, dn[k], 1'b0);
            chk("gap_tx", k, txo[k], 1'b1);
        end
    endtask
    initial begin
        st = '0;
        tk = '0;
        for (int k = 0; k < 4; k++) dat[k] = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st = 4'($urandom);
            tk = 4'($urandom);
            step();
            chk_idle("reset");
        end
        rst = 1'b0;
        st = '0;
        tk = '0;
        step();
        chk_idle("after_reset");
        idle_noise(5);
        send(0, 8'hA5, 4, 1'b0, -1, 1'b0);
        send(1, 8'h07, 0, 1'b0, -1, 1'b0);
        send(2, 8'h07, 0, 1'b0, -1, 1'b0);
        send(1, 8'h00, 0, 1'b0, -1, 1'b0);
        send(3, 8'hFF, 3, 1'b0, -1, 1'b0);
        idle_noise(3);
        send(0, 8'h5A, 2, 1'b1, -1, 1'b1);
        send(0, 8'($urandom), 0, 1'b0, -1, 1'b0);
        send(0, 8'($urandom), 3, 1'b0, 5, 1'b0);
        send(0, 8'($urandom), 0, 1'b0, -1, 1'b0);
        for (int n = 0; n < 12; n++) begin
            send(int'($urandom_range(0, 3)), 8'($urandom), 0, 1'($urandom), -1, 1'($urandom));
        end
        step();
        idle_noise(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
